result_framer: RTL and testbench
================================

RESULT_FRAMER -- requirements
Module: result_framer

Interface
REQ-001 Parameter MAX_K, default 8: result buffer depth and maximum results per frame.
REQ-002 Parameter TAG_W, default 8: handshake tag width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk_in  input  1  system clock.
REQ-005 rst_in  input  1  asynchronous active-high reset.
REQ-006 start_in  input  1  one-cycle pulse; a query was issued; arms collection.
REQ-007 k_in  input  16  number of results expected for this query, sampled on start_in.
REQ-008 result_in  input  32  result vertex id from the search engine.
REQ-009 result_valid_in  input  1  result_in valid this cycle.
REQ-010 cycles_in  input  32  free-running query cycle count.
REQ-011 ack_in  input  TAG_W  host-written tag of the last word consumed.
REQ-012 tx_data_out  output  32  word currently offered to the host.
REQ-013 tx_tag_out  output  TAG_W  tag of tx_data_out; it changes exactly when a new word is offered.
REQ-014 busy_out  output  1  high in any state other than IDLE.
REQ-015 overflow_out  output  1  sticky flag; a result arrived outside COLLECT or beyond the expected count.
REQ-016 frame_done_out  output  1  one-cycle pulse after the final frame word is acknowledged.

Function
REQ-017 States: IDLE, COLLECT, HDR, CNT, DATA, CYC.
REQ-018 IDLE, start_in=1: latch K = min(k_in, MAX_K); clear capture count; go to COLLECT.
REQ-019 COLLECT, result_valid_in=1 with capture count < K: write result_in into buffer slot [count]; increment count.
REQ-020 COLLECT exit: on the cycle count reaches K, latch cycles_in and go to HDR; K=0 goes to HDR on the cycle after start_in.
REQ-021 Word offer: each transition into HDR, CNT, DATA (per word) or CYC SHALL load tx_data_out and set tx_tag_out <= tx_tag_out+1, both in the same cycle.
REQ-022 Tag arithmetic: tx_tag_out increments modulo 2^TAG_W and wraps without special handling.
REQ-023 Words offered per frame, in order:
  - HDR: 0xFFFFFFFF
  - CNT: zero-extended K
  - DATA: buffer slots 0..K-1
  - CYC: latched cycles
REQ-024 Advance: in HDR/CNT/DATA/CYC, when ack_in == tx_tag_out, the next word is offered on the following clock (1-cycle latency); otherwise outputs hold.
REQ-025 CNT with K=0: acknowledgment goes directly to CYC.
REQ-026 CYC acknowledged: go to IDLE and pulse frame_done_out for that one cycle; tx_data_out and tx_tag_out hold.
REQ-027 ack_in is ignored in IDLE and COLLECT.
REQ-028 start_in while busy_out=1 SHALL be ignored.
REQ-029 Overflow: result_valid_in outside COLLECT, or in COLLECT with count already K, SHALL be dropped and set overflow_out.
REQ-030 overflow_out clears only on start_in accepted in IDLE, or on reset.
REQ-031 k_in > MAX_K: K clamps to MAX_K; the extra results set overflow_out.
REQ-032 result_in values equal to 0xFFFFFFFF are sent unescaped; the host uses the CNT word for framing.

Reset
REQ-033 rst_in=1 asynchronously forces:
  - state IDLE
  - tx_data_out=0, tx_tag_out=0
  - busy_out=0, overflow_out=0, frame_done_out=0
  - capture count=0, K=0
REQ-034 Reset mid-frame SHALL abandon the frame; buffer contents need not be cleared.
REQ-035 The first frame after reset SHALL offer its header with tag 1.

Verification
REQ-036 Reset; start_in with k_in=3; results 0x11,0x22,0x33; cycles_in=500 -> tag1 0xFFFFFFFF; after ack_in=1, tag2 3; then tags 3..5 = 0x11,0x22,0x33; tag6 500; ack_in=6 -> frame_done_out pulse, busy_out=0.
REQ-037 Host withholds ack for 100 cycles at tag2 -> tx_data_out=3 and tx_tag_out=2 stable throughout; ack_in=2 -> tag3 exactly one cycle later.
REQ-038 k_in=0 -> header, then count 0, then cycles word (tags 1,2,3); no DATA words.
REQ-039 k_in=10, MAX_K=8, 10 results -> count word 8, first 8 results sent, overflow_out=1 until next accepted start_in.
REQ-040 Start with tx_tag_out=254 and run a 4-word frame -> tags 255,0,1,2; no stall at wrap.
REQ-041 Assert rst_in during DATA -> all outputs 0 immediately; new start_in with k_in=1 completes normally with header tag 1.

Source files
------------

// File: rtl/result_framer_if.sv
// Query/result and host word-handshake signals of the result framer.
// The slave side is the framer; the master side is the engine/host.
interface result_framer_if #(
  parameter int unsigned TAG_W = 8
);
  logic             start_in;
  logic [15:0]      k_in;
  logic [31:0]      result_in;
  logic             result_valid_in;
  logic [31:0]      cycles_in;
  logic [TAG_W-1:0] ack_in;
  logic [31:0]      tx_data_out;
  logic [TAG_W-1:0] tx_tag_out;
  logic             busy_out;
  logic             overflow_out;
  logic             frame_done_out;

  modport master (
    output start_in, k_in, result_in, result_valid_in, cycles_in, ack_in,
    input  tx_data_out, tx_tag_out, busy_out, overflow_out, frame_done_out
  );

  modport slave (
    input  start_in, k_in, result_in, result_valid_in, cycles_in, ack_in,
    output tx_data_out, tx_tag_out, busy_out, overflow_out, frame_done_out
  );
endinterface

// File: rtl/result_framer.sv
// Collects up to K search results per query and offers them to the host as
// a tagged frame: header, count, results, cycle count.
module result_framer #(
  parameter int unsigned MAX_K = 8,
  parameter int unsigned TAG_W = 8
) (
  input logic            clk_in,
  input logic            rst_in,
  result_framer_if.slave bus
);

  localparam int unsigned AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, HDR, CNT, DATA, CYC} state_t;

  state_t           state_q, state_d;
  logic [15:0]      k_q, k_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      rd_q, rd_d;
  logic [31:0]      cyc_q;
  logic [31:0]      tx_data_q;
  logic [TAG_W-1:0] tx_tag_q;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             load, wr_en, cyc_latch, acked;
  logic [31:0]      word_d;
  logic [15:0]      k_clamp;
  logic [31:0]      mem_q [MAX_K];

  assign k_clamp = (bus.k_in > 16'(MAX_K)) ? 16'(MAX_K) : bus.k_in;
  assign acked   = (bus.ack_in == tx_tag_q);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    load      = 1'b0;
    wr_en     = 1'b0;
    cyc_latch = 1'b0;
    word_d    = '0;
    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          k_d     = k_clamp;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.result_valid_in) begin
          if (cnt_q < k_q) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 16'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        // Compare the updated count so the header goes out on the same edge
        // that captures the last result (and one cycle after start for K=0).
        if (cnt_d == k_q) begin
          cyc_latch = 1'b1;
          load      = 1'b1;
          word_d    = '1;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (acked) begin
          load    = 1'b1;
          word_d  = 32'(k_q);
          state_d = CNT;
        end
      end
      CNT: begin
        if (acked) begin
          load = 1'b1;
          if (k_q == 16'd0) begin
            word_d  = cyc_q;
            state_d = CYC;
          end else begin
            word_d  = mem_q[0];
            rd_d    = 16'd1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (acked) begin
          load = 1'b1;
          if (rd_q == k_q) begin
            word_d  = cyc_q;
            state_d = CYC;
          end else begin
            word_d = mem_q[rd_q[AW-1:0]];
            rd_d   = rd_q + 16'd1;
          end
        end
      end
      CYC: begin
        if (acked) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.result_valid_in && state_q != COLLECT)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      cyc_q     <= '0;
      tx_data_q <= '0;
      tx_tag_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      if (cyc_latch)
        cyc_q <= bus.cycles_in;
      if (load) begin
        tx_data_q <= word_d;
        tx_tag_q  <= tx_tag_q + TAG_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en)
      mem_q[cnt_q[AW-1:0]] <= bus.result_in;
  end

  assign bus.tx_data_out    = tx_data_q;
  assign bus.tx_tag_out     = tx_tag_q;
  assign bus.busy_out       = (state_q != IDLE);
  assign bus.overflow_out   = ovf_q;
  assign bus.frame_done_out = done_q;

endmodule

// File: tb/tb_result_framer.sv
// Scoreboard bench for result_framer: frames are queued as expected words when
// a query is issued and an independent monitor checks each offered word.
module tb_result_framer;

  logic clk_100mhz = 1'b0;
  logic rst;

  always #5 clk_100mhz = ~clk_100mhz;

  result_framer_if #(.TAG_W(8)) bus ();

  result_framer #(.MAX_K(8), .TAG_W(8)) dut (
    .clk_in (clk_100mhz),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] data;
  } word_t;

  word_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_tag = '0;
  logic [31:0] res_v [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every tag change outside reset is a newly offered word.
  initial begin
    logic [7:0] last;
    word_t      w;
    last = '0;
    forever begin
      @(negedge clk_100mhz);
      if (rst) begin
        last = '0;
      end else if (bus.tx_tag_out != last) begin
        last = bus.tx_tag_out;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got tag %0d data 0x%08h, expected no word",
                   bus.tx_tag_out, bus.tx_data_out);
        end else begin
          w = exp_q.pop_front();
          check("word_tag", 32'(bus.tx_tag_out), 32'(w.tag));
          check("word_data", bus.tx_data_out, w.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_frame(input int k, input int nres, input logic [31:0] cyc,
                           input int stall_idx, input bit poke_start, input int abort_idx);
    int          kk;
    int          nwords;
    int          t;
    bit          ok;
    logic [7:0]  t0;
    logic [7:0]  tg;
    logic [7:0]  tn;
    logic [31:0] w [0:15];
    kk     = (k > 8) ? 8 : k;
    nwords = kk + 3;
    t0     = model_tag;
    w[0]   = 32'hFFFF_FFFF;
    w[1]   = 32'(kk);
    for (int i = 0; i < kk; i++) w[2+i] = res_v[i];
    w[2+kk] = cyc;
    for (int i = 0; i < nwords; i++) begin
      model_tag = model_tag + 8'd1;
      exp_q.push_back({model_tag, w[i]});
    end

    @(negedge clk_100mhz);
    bus.start_in  = 1'b1;
    bus.k_in      = 16'(k);
    bus.cycles_in = cyc;
    @(negedge clk_100mhz);
    bus.start_in = 1'b0;
    check("ovf_clear_on_start", 32'(bus.overflow_out), 32'd0);
    check("busy_collect", 32'(bus.busy_out), 32'd1);
    for (int i = 0; i < nres; i++) begin
      bus.result_in       = res_v[i];
      bus.result_valid_in = 1'b1;
      @(negedge clk_100mhz);
    end
    bus.result_valid_in = 1'b0;
    @(negedge clk_100mhz);
    bus.cycles_in = cyc ^ 32'hDEAD_0000;

    for (int i = 0; i < nwords; i++) begin
      tg = t0 + 8'(i + 1);
      tn = tg + 8'd1;
      t  = 0;
      while (bus.tx_tag_out != tg && t < 200) begin
        @(negedge clk_100mhz);
        t++;
      end
      if (bus.tx_tag_out != tg) begin
        checks++;
        errors++;
        $display("FAIL word_timeout: tag %0d, expected tag %0d within 200 cycles",
                 bus.tx_tag_out, tg);
        return;
      end
      if (i == stall_idx) begin
        ok = 1'b1;
        repeat (100) begin
          @(negedge clk_100mhz);
          if (bus.tx_tag_out != tg || bus.tx_data_out != w[i]) ok = 1'b0;
        end
        check("stall_hold", 32'(ok), 32'd1);
      end
      if (poke_start && i == 1) begin
        bus.start_in = 1'b1;
        bus.k_in     = 16'd5;
        @(negedge clk_100mhz);
        bus.start_in = 1'b0;
        check("busy_ignores_start", 32'(bus.busy_out), 32'd1);
      end
      if (i == abort_idx) begin
        #2 rst = 1'b1;
        #1;
        check("rst_data", bus.tx_data_out, 32'd0);
        check("rst_tag", 32'(bus.tx_tag_out), 32'd0);
        check("rst_busy", 32'(bus.busy_out), 32'd0);
        check("rst_ovf", 32'(bus.overflow_out), 32'd0);
        check("rst_done", 32'(bus.frame_done_out), 32'd0);
        bus.ack_in = '0;
        exp_q.delete();
        model_tag = '0;
        @(negedge clk_100mhz);
        #2 rst = 1'b0;
        return;
      end
      bus.ack_in = tg;
      @(negedge clk_100mhz);
      if (i < nwords - 1) begin
        check("ack_latency", 32'(bus.tx_tag_out), 32'(tn));
      end else begin
        check("frame_done", 32'(bus.frame_done_out), 32'd1);
        check("busy_idle", 32'(bus.busy_out), 32'd0);
        check("hold_after_done", bus.tx_data_out, cyc);
        @(negedge clk_100mhz);
        check("done_pulse", 32'(bus.frame_done_out), 32'd0);
      end
    end
  endtask

  initial begin
    int need;
    rst                 = 1'b1;
    bus.start_in        = 1'b0;
    bus.k_in            = '0;
    bus.result_in       = '0;
    bus.result_valid_in = 1'b0;
    bus.cycles_in       = '0;
    bus.ack_in          = '0;
    repeat (2) @(negedge clk_100mhz);
    check("reset_data", bus.tx_data_out, 32'd0);
    check("reset_tag", 32'(bus.tx_tag_out), 32'd0);
    check("reset_busy", 32'(bus.busy_out), 32'd0);
    check("reset_ovf", 32'(bus.overflow_out), 32'd0);
    check("reset_done", 32'(bus.frame_done_out), 32'd0);
    #2 rst = 1'b0;

    // Basic 3-result frame; host stalls 100 cycles on the count word (tag 2).
    res_v[0] = 32'h11; res_v[1] = 32'h22; res_v[2] = 32'h33;
    run_frame(3, 3, 32'd500, 1, 1'b0, -1);
    check("no_ovf_normal", 32'(bus.overflow_out), 32'd0);

    run_frame(0, 0, 32'd777, -1, 1'b0, -1);

    // More results than MAX_K: clamp to 8, the surplus sets the sticky flag.
    for (int i = 0; i < 10; i++) res_v[i] = 32'h1000 + 32'(i);
    run_frame(10, 10, 32'd1234, -1, 1'b0, -1);
    check("ovf_set", 32'(bus.overflow_out), 32'd1);
    repeat (3) @(negedge clk_100mhz);
    check("ovf_sticky", 32'(bus.overflow_out), 32'd1);

    // Result equal to the header pattern, plus a start pulse while busy.
    res_v[0] = 32'hFFFF_FFFF; res_v[1] = 32'h55;
    run_frame(2, 2, 32'd42, -1, 1'b1, -1);
    check("ovf_cleared", 32'(bus.overflow_out), 32'd0);

    // Advance the tag to 254 with 3- and 4-word frames.
    need = 254 - int'(model_tag);
    while (need > 0) begin
      res_v[0] = 32'h200 + 32'(need);
      if (need % 3 == 0) begin
        run_frame(0, 0, 32'(need), -1, 1'b0, -1);
        need -= 3;
      end else begin
        run_frame(1, 1, 32'(need), -1, 1'b0, -1);
        need -= 4;
      end
    end
    check("tag_pre_wrap", 32'(bus.tx_tag_out), 32'd254);

    res_v[0] = 32'hBEEF;
    run_frame(1, 1, 32'd9000, -1, 1'b0, -1);

    // Reset while the first DATA word is offered; the 4th result sets overflow.
    res_v[0] = 32'hA1; res_v[1] = 32'hA2; res_v[2] = 32'hA3; res_v[3] = 32'hA4;
    run_frame(3, 4, 32'd321, -1, 1'b0, 2);

    res_v[0] = 32'hCAFE;
    run_frame(1, 1, 32'd55, -1, 1'b0, -1);

    repeat (3) @(negedge clk_100mhz);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
